// File: rtl/data_memory_ls_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_memory_ls_pkg                                           |
// | Description : Shared funct3 encodings, response error codes, the pipeline  |
// |               stage record and access-decode helpers for data_memory_ls.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package data_memory_ls_pkg;

    // RV32I load/store width encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_OOB      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // One slot of the response pipeline; all-zero means "no response"
    typedef struct packed {
        logic        valid;
        logic [1:0]  err;
        logic [31:0] rdata;
    } resp_t;

    // Unsigned widths have no store form, and 011/110/111 are not memory ops
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic r;
        case (funct3)
            F3_B, F3_H, F3_W: r = 1'b0;
            F3_BU, F3_HU:     r = we;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    // Halves need an even address, words a multiple of four
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic r;
        case (funct3)
            F3_H, F3_HU: r = lane[0];
            F3_W:        r = (lane != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_ls_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_extend                                                  |
// | Description : Selects the addressed byte/half of a memory word and sign-   |
// |               or zero-extends it to 32 bits according to funct3.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_extend
    import data_memory_ls_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane selection; halves are aligned so only lane[1] matters
    always_comb begin
        w_byte = word[7:0];
        case (lane)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = lane[1] ? word[31:16] : word[15:0];
    end

    // Width and signedness of the returned value
    always_comb begin
        data = 32'h0;
        case (funct3)
            F3_B:    data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data = {24'h0, w_byte};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'h0, w_half};
            F3_W:    data = word;
            default: data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ls.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_memory_ls                                               |
// | Description : MEM-stage data memory with RV32I byte/half/word loads and    |
// |               stores, fault reporting and a fixed-latency response pipe.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_memory_ls
    import data_memory_ls_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);
    localparam int c_LAST  = READ_LATENCY - 1;

    // Contents start at zero at elaboration and are deliberately not reset
    logic [31:0] r_mem [MEM_WORDS] = '{default: 32'h0};

    resp_t r_pipe [READ_LATENCY];

    logic               w_accept;
    logic [31:0]        w_addr;
    logic [1:0]         w_lane;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_err;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_ext;
    resp_t              w_stage0;

    // No backpressure: ready follows reset only
    assign req_ready = rstn;
    assign w_accept  = req_valid & req_ready;

    // Effective address wraps modulo 2^32
    assign w_addr = req_base + req_offset;
    assign w_lane = w_addr[1:0];
    assign w_idx  = w_addr[c_IDX_W+1:2];

    // Fault decode with priority illegal > misaligned > out of range
    always_comb begin
        w_err = ERR_OK;
        if (is_illegal(req_we, req_funct3)) begin
            w_err = ERR_ILLEGAL;
        end else if (is_misaligned(req_funct3, w_lane)) begin
            w_err = ERR_MISALIGN;
        end else if (w_addr[31:2] >= 30'(MEM_WORDS)) begin
            w_err = ERR_OOB;
        end
    end

    // Byte enables and lane-replicated store data; faulted or unaccepted stores write nothing
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_funct3)
            F3_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (!(w_accept && req_we && (w_err == ERR_OK))) begin
            w_be = 4'b0000;
        end
    end

    // Per-byte write in the accept cycle
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Array read in the accept cycle; a load right after a store sees the new bytes
    assign w_rd_word = r_mem[w_idx];

    load_extend u_load_extend (
        .word   (w_rd_word),
        .lane   (w_lane),
        .funct3 (req_funct3),
        .data   (w_ext)
    );

    // Stage-0 record: stores and faults carry zero data, idle cycles carry all zeros
    always_comb begin
        w_stage0 = '0;
        if (w_accept) begin
            w_stage0.valid = 1'b1;
            w_stage0.err   = w_err;
            if (!req_we && (w_err == ERR_OK)) begin
                w_stage0.rdata = w_ext;
            end
        end
    end

    // Fixed-latency shift pipeline; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    // Outputs are forced quiet for the whole time reset is held
    assign resp_valid = rstn & r_pipe[c_LAST].valid;
    assign resp_rdata = rstn ? r_pipe[c_LAST].rdata : 32'h0;
    assign resp_err   = rstn ? r_pipe[c_LAST].err   : ERR_OK;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ls.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_memory_ls                                            |
// | Description : Self-checking bench for data_memory_ls at latencies 3 and 1  |
// |               with a byte-addressed reference model.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_memory_ls;
    import data_memory_ls_pkg::*;

    localparam int MW   = 1024;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_base = 32'h0;
    logic [31:0] req_offset = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        rdy3, v3, rdy1, v1;
    logic [31:0] d3, d1;
    logic [1:0]  e3, e1;

    data_memory_ls #(.MEM_WORDS(MW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(v3), .resp_rdata(d3), .resp_err(e3)
    );

    data_memory_ls #(.MEM_WORDS(MW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(v1), .resp_rdata(d1), .resp_err(e1)
    );

    always #5 clk = ~clk;

    // Reference model: byte-addressed memory and per-cycle expected responses
    byte unsigned mref [MW*4];
    bit          hv  [HMAX];
    bit          hg  [HMAX];
    logic [31:0] hd  [HMAX];
    logic [1:0]  he  [HMAX];
    logic [31:0] hgd [HMAX];
    logic [1:0]  hge [HMAX];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic        cur_gen = 1'b0;
    logic [31:0] cur_gd  = 32'h0;
    logic [1:0]  cur_ge  = 2'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Apply the architectural rules to the request present at this clock edge
    task automatic model_edge();
        int unsigned a, widx, lane, size;
        logic        sgn, ill, mis;
        logic [1:0]  err;
        logic [31:0] val;
        if (!rstn) begin
            for (int k = 0; k < HMAX; k++) hv[k] = 1'b0;
            return;
        end
        hv[cyc] = 1'b0;
        if (!req_valid) return;
        a    = req_base + req_offset;
        widx = a >> 2;
        lane = a % 4;
        size = 0;
        sgn  = 1'b0;
        case (req_funct3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        ill = (size == 0) || (req_we && req_funct3[2]);
        mis = (size == 2 && (a % 2) != 0) || (size == 4 && lane != 0);
        err = ill ? 2'd3 : mis ? 2'd1 : (widx >= MW) ? 2'd2 : 2'd0;
        val = 32'h0;
        if (err == 2'd0) begin
            if (req_we) begin
                for (int i = 0; i < int'(size); i++) mref[a + i] = req_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(size); i++) val = val | (32'(mref[a + i]) << (8*i));
                if (sgn && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
                if (sgn && size == 2 && val[15]) val = val | 32'hFFFF_0000;
            end
        end
        hv[cyc]  = 1'b1;
        hd[cyc]  = val;
        he[cyc]  = err;
        hg[cyc]  = cur_gen;
        hgd[cyc] = cur_gd;
        hge[cyc] = cur_ge;
    endtask

    task automatic check_dut(input string nm, input int lat, input logic rdy,
                             input logic v, input logic [31:0] d, input logic [1:0] e);
        int          a;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  ee;
        a  = cyc - lat;
        ev = 1'b0;
        ed = 32'h0;
        ee = 2'b0;
        if (rstn && a >= 0 && hv[a]) begin
            ev = 1'b1;
            ed = hd[a];
            ee = he[a];
        end
        chk({nm, " req_ready"},  {31'h0, rdy}, {31'h0, rstn});
        chk({nm, " resp_valid"}, {31'h0, v},   {31'h0, ev});
        chk({nm, " resp_rdata"}, d,            ed);
        chk({nm, " resp_err"},   {30'h0, e},   {30'h0, ee});
        if (ev && hg[a]) begin
            chk({nm, " directed rdata"}, d,          hgd[a]);
            chk({nm, " directed err"},   {30'h0, e}, {30'h0, hge[a]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_dut("lat3", 3, rdy3, v3, d3, e3);
        check_dut("lat1", 1, rdy1, v1, d1, e1);
    endtask

    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd,
                       input logic gen, input logic [31:0] gd, input logic [1:0] ge);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        cur_gen    = gen;
        cur_gd     = gd;
        cur_ge     = ge;
        tick();
        req_valid  = 1'b0;
        cur_gen    = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] base, off;
        int          o;

        // Reset state
        rstn = 1'b0;
        @(negedge clk);
        idle(3);
        rstn = 1'b1;
        idle(1);

        // Store then back-to-back loads of every width
        req(1'b1, F3_W,  32'h100, 32'h4, 32'hDEAD_BEEF, 1'b1, 32'h0, ERR_OK);
        req(1'b0, F3_W,  32'h100, 32'h4, 32'h0, 1'b1, 32'hDEAD_BEEF, ERR_OK);
        req(1'b0, F3_B,  32'h107, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFDE, ERR_OK);
        req(1'b0, F3_BU, 32'h107, 32'h0, 32'h0, 1'b1, 32'h0000_00DE, ERR_OK);
        req(1'b0, F3_H,  32'h106, 32'h0, 32'h0, 1'b1, 32'hFFFF_DEAD, ERR_OK);
        req(1'b0, F3_HU, 32'h104, 32'h0, 32'h0, 1'b1, 32'h0000_BEEF, ERR_OK);
        idle(4);

        // Partial writes
        req(1'b1, F3_B,  32'h105, 32'h0, 32'h0000_0055, 1'b1, 32'h0, ERR_OK);
        req(1'b1, F3_H,  32'h106, 32'h0, 32'h0000_1234, 1'b1, 32'h0, ERR_OK);
        req(1'b0, F3_W,  32'h104, 32'h0, 32'h0, 1'b1, 32'h1234_55EF, ERR_OK);

        // Negative offset
        req(1'b1, F3_W,  32'h10, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b1, 32'h0, ERR_OK);
        req(1'b0, F3_W,  32'hC,  32'h0, 32'h0, 1'b1, 32'hA5A5_A5A5, ERR_OK);

        // Faults
        req(1'b0, F3_W,   32'h102,  32'h0, 32'h0, 1'b1, 32'h0, ERR_MISALIGN);
        req(1'b1, F3_W,   32'h1000, 32'h0, 32'hCAFE_BABE, 1'b1, 32'h0, ERR_OOB);
        req(1'b0, F3_W,   32'h0,    32'h0, 32'h0, 1'b1, 32'h0, ERR_OK);
        req(1'b0, 3'b011, 32'h100,  32'h0, 32'h0, 1'b1, 32'h0, ERR_ILLEGAL);
        req(1'b1, F3_BU,  32'h100,  32'h0, 32'hFF, 1'b1, 32'h0, ERR_ILLEGAL);
        idle(5);

        // Reset one cycle after a load; a store offered during reset must not land
        req(1'b0, F3_W, 32'h104, 32'h0, 32'h0, 1'b1, 32'h1234_55EF, ERR_OK);
        rstn       = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_base   = 32'h104;
        req_offset = 32'h0;
        req_wdata  = 32'hFFFF_FFFF;
        tick();
        tick();
        tick();
        req_valid = 1'b0;
        rstn      = 1'b1;
        idle(4);
        req(1'b0, F3_W, 32'h104, 32'h0, 32'h0, 1'b1, 32'h1234_55EF, ERR_OK);
        idle(4);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rstn = 1'b0;
                idle(2);
                rstn = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                idle(1);
            end else begin
                we = 1'($urandom_range(0, 1));
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                 : 3'($urandom_range(0, 5));
                case ($urandom_range(0, 9))
                    0:       base = 32'h0000_1000 + 32'($urandom_range(0, 255));
                    1:       base = $urandom;
                    default: base = 32'($urandom_range(0, 32'h1FF));
                endcase
                o   = int'($urandom_range(0, 64)) - 32;
                off = o;
                req(we, f3, base, off, $urandom, 1'b0, 32'h0, 2'b0);
            end
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
